// File: rtl/ssd_pkg.sv
// Shared seven-segment constants (active-low, bit0=a .. bit6=g) and capture FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ssd_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DECODE = 2'd2
  } cap_state_e;

endpackage

// File: rtl/ssd_capture_if.sv
// Display bus between a two-digit multiplexed seven-segment driver and its capture monitor.
// Latency: n/a (wiring only).
// Backpressure: none; the display bus is free-running.
interface ssd_capture_if;
  logic [6:0] ssd_in;
  logic       ssdcat_in;
  logic [7:0] value;
  logic       valid;
  logic       seg_err;
  logic       stale;

  modport master (
    output ssd_in, ssdcat_in,
    input  value, valid, seg_err, stale
  );

  modport slave (
    input  ssd_in, ssdcat_in,
    output value, valid, seg_err, stale
  );
endinterface

// File: rtl/ssd_seg_decode.sv
// Active-low seven-segment pattern to BCD digit, flagging anything that is not 0-9.
// Latency: combinational.
// Backpressure: none.
module ssd_seg_decode
  import ssd_pkg::*;
(
  input  logic [6:0]         seg,
  output logic [DIGIT_W-1:0] digit,
  output logic               legal
);

  always_comb begin
    digit = '0;
    legal = 1'b1;
    case (seg)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/ssd_capture.sv
// Rebuilds the BCD pair shown on a multiplexed two-digit display; SSD_CAPTURE_SYNC_EN adds input synchronisers.
// Latency: valid/seg_err L+SETTLE_CYCLES+2 cycles after a select edge (L=2 synchronised, else 0).
// Backpressure: none; results are single-cycle pulses that must be consumed when seen.
module ssd_capture
  import ssd_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic          clk,
  input  logic          rst,
  ssd_capture_if.slave  bus
);

  localparam int SCNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [6:0] seg_s;
  logic       cat_s;

`ifdef SSD_CAPTURE_SYNC_EN
  logic [6:0] seg_m;
  logic       cat_m;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_m <= SEG_BLANK;
      seg_s <= SEG_BLANK;
      cat_m <= 1'b0;
      cat_s <= 1'b0;
    end else begin
      seg_m <= bus.ssd_in;
      seg_s <= seg_m;
      cat_m <= bus.ssdcat_in;
      cat_s <= cat_m;
    end
  end
`else
  assign seg_s = bus.ssd_in;
  assign cat_s = bus.ssdcat_in;
`endif

  logic sel_prev;
  logic sel_edge;

  assign sel_edge = cat_s ^ sel_prev;

  cap_state_e        state, state_nxt;
  logic              idx, idx_nxt;
  logic [6:0]        pat, pat_nxt;
  logic [SCNT_W-1:0] scnt, scnt_nxt;
  logic              do_decode;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 1'b0;
      pat      <= SEG_BLANK;
      scnt     <= '0;
      sel_prev <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      pat      <= pat_nxt;
      scnt     <= scnt_nxt;
      sel_prev <= cat_s;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    pat_nxt   = pat;
    scnt_nxt  = scnt;
    do_decode = 1'b0;
    case (state)
      IDLE: begin
        if (sel_edge) begin
          idx_nxt   = cat_s;
          pat_nxt   = seg_s;
          scnt_nxt  = '0;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        // A new select edge abandons the digit in flight; a changed pattern restarts settling.
        if (sel_edge) begin
          idx_nxt  = cat_s;
          pat_nxt  = seg_s;
          scnt_nxt = '0;
        end else if (seg_s != pat) begin
          pat_nxt  = seg_s;
          scnt_nxt = '0;
        end else if (scnt == SCNT_W'(SETTLE_CYCLES)) begin
          state_nxt = DECODE;
        end else begin
          scnt_nxt = scnt + SCNT_W'(1);
        end
      end
      DECODE: begin
        do_decode = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic [DIGIT_W-1:0] dig;
  logic               legal;

  ssd_seg_decode u_dec (
    .seg   (pat),
    .digit (dig),
    .legal (legal)
  );

  logic [DIGIT_W-1:0] lo_dig;
  logic               have_lo;
  logic [7:0]         value_q;
  logic               valid_q;
  logic               seg_err_q;
  logic               stale_q;
  logic [TCNT_W-1:0]  tcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_dig    <= '0;
      have_lo   <= 1'b0;
      value_q   <= 8'h00;
      valid_q   <= 1'b0;
      seg_err_q <= 1'b0;
      stale_q   <= 1'b0;
      tcnt      <= '0;
    end else begin
      valid_q   <= 1'b0;
      seg_err_q <= 1'b0;

      if (do_decode) begin
        if (!legal) begin
          seg_err_q <= 1'b1;
          have_lo   <= 1'b0;
        end else if (!idx) begin
          lo_dig  <= dig;
          have_lo <= 1'b1;
        end else if (have_lo) begin
          value_q <= {dig, lo_dig};
          valid_q <= 1'b1;
          have_lo <= 1'b0;
          stale_q <= 1'b0;
        end
      end

      if (sel_edge) begin
        tcnt <= '0;
      end else if (tcnt != TCNT_W'(TIMEOUT_CYCLES)) begin
        tcnt <= tcnt + TCNT_W'(1);
      end

      // Going stale drops any half-built pair so an old low digit cannot pair with a fresh high.
      if (!sel_edge && tcnt == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
        stale_q <= 1'b1;
        have_lo <= 1'b0;
      end
    end
  end

  assign bus.value   = value_q;
  assign bus.valid   = valid_q;
  assign bus.seg_err = seg_err_q;
  assign bus.stale   = stale_q;

endmodule

// File: tb/tb_ssd_capture.sv
// Directed bench for ssd_capture: pairing, illegal patterns, settle restart, stale timeout and reset.
module tb_ssd_capture;
  import ssd_pkg::*;

  localparam int S = 4;
  localparam int T = 4096;
`ifdef SSD_CAPTURE_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ssd_capture_if bus();

  ssd_capture #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   v_cnt, e_cnt, v_lat, e_lat, s_lat, both;
  logic stale_at_v;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one digit for 'hold' cycles; optionally swap the pattern after tick 'chg_at'.
  // Latencies are counted from the edge that first samples the new inputs.
  task automatic drive(input logic sel, input logic [6:0] pat, input int hold,
                       input int chg_at, input logic [6:0] pat2);
    bus.ssdcat_in = sel;
    bus.ssd_in    = pat;
    v_cnt = 0; e_cnt = 0; v_lat = -1; e_lat = -1; s_lat = -1; both = 0;
    stale_at_v = 1'bx;
    for (int n = 1; n <= hold; n++) begin
      tick;
      if (n == chg_at) bus.ssd_in = pat2;
      if (bus.valid === 1'b1) begin
        v_cnt++;
        if (v_lat < 0) begin
          v_lat      = n - 1;
          stale_at_v = bus.stale;
        end
      end
      if (bus.seg_err === 1'b1) begin
        e_cnt++;
        if (e_lat < 0) e_lat = n - 1;
      end
      if (bus.valid === 1'b1 && bus.seg_err === 1'b1) both++;
      if (bus.stale === 1'b1 && s_lat < 0) s_lat = n - 1;
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.ssdcat_in = 1'b0;
    bus.ssd_in    = SEG_BLANK;
    repeat (3) tick;
    chk("reset_value",   32'(bus.value),   32'h00);
    chk("reset_valid",   32'(bus.valid),   32'h0);
    chk("reset_seg_err", 32'(bus.seg_err), 32'h0);
    chk("reset_stale",   32'(bus.stale),   32'h0);
    rst = 1'b0;

    // High digit with no preceding low completes nothing.
    drive(1'b1, SEG_4, 50, 0, SEG_4);
    chk("hi_only_no_valid", 32'(v_cnt), 32'd0);
    chk("hi_only_no_err",   32'(e_cnt), 32'd0);
    drive(1'b0, SEG_2, 50, 0, SEG_2);
    chk("lo_no_valid", 32'(v_cnt), 32'd0);

    drive(1'b1, SEG_4, 50, 0, SEG_4);
    chk("pair42_valid_cnt", 32'(v_cnt), 32'd1);
    chk("pair42_latency",   32'(v_lat), 32'(L + S + 2));
    chk("pair42_value",     32'(bus.value), 32'h42);
    chk("pair42_no_err",    32'(e_cnt), 32'd0);

    drive(1'b0, SEG_2, 50, 0, SEG_2);
    drive(1'b1, SEG_4, 50, 0, SEG_4);
    chk("pair42b_valid_cnt", 32'(v_cnt), 32'd1);
    chk("pair42b_value",     32'(bus.value), 32'h42);

    // Blank high digit is illegal: one error pulse, value untouched.
    drive(1'b0, SEG_0, 50, 0, SEG_0);
    drive(1'b1, SEG_BLANK, 50, 0, SEG_BLANK);
    chk("blank_err_cnt",   32'(e_cnt), 32'd1);
    chk("blank_err_lat",   32'(e_lat), 32'(L + S + 2));
    chk("blank_no_valid",  32'(v_cnt), 32'd0);
    chk("blank_value_hold", 32'(bus.value), 32'h42);

    drive(1'b0, SEG_0, 50, 0, SEG_0);
    drive(1'b1, SEG_1, 50, 0, SEG_1);
    chk("pair10_valid_cnt", 32'(v_cnt), 32'd1);
    chk("pair10_value",     32'(bus.value), 32'h10);
    chk("pair10_no_overlap", 32'(both), 32'd0);

    // Pattern swaps 2 cycles into settling: the first pattern (5) must never be decoded.
    drive(1'b0, SEG_2, 50, 0, SEG_2);
    drive(1'b1, SEG_5, 50, 2, SEG_4);
    chk("resettle_valid_cnt", 32'(v_cnt), 32'd1);
    chk("resettle_latency",   32'(v_lat), 32'(L + S + 4));
    chk("resettle_value",     32'(bus.value), 32'h42);
    chk("resettle_no_err",    32'(e_cnt), 32'd0);

    // Select held: stale after the timeout, and the stored low digit is dropped.
    drive(1'b0, SEG_2, T + L + 20, 0, SEG_2);
    chk("stale_latency",    32'(s_lat), 32'(L + T));
    chk("stale_value_hold", 32'(bus.value), 32'h42);
    drive(1'b1, SEG_4, 50, 0, SEG_4);
    chk("stale_drops_low", 32'(v_cnt), 32'd0);
    chk("stale_still_set", 32'(bus.stale), 32'h1);
    drive(1'b0, SEG_0, 50, 0, SEG_0);
    drive(1'b1, SEG_1, 50, 0, SEG_1);
    chk("unstale_valid_cnt",    32'(v_cnt), 32'd1);
    chk("unstale_stale_at_vld", 32'(stale_at_v), 32'h0);
    chk("unstale_value",        32'(bus.value), 32'h10);

    // Reset while a high digit settles after a stored low digit.
    drive(1'b0, SEG_2, 50, 0, SEG_2);
    bus.ssdcat_in = 1'b1;
    bus.ssd_in    = SEG_4;
    repeat (L + 2) tick;
    rst = 1'b1;
    tick;
    chk("midrst_value",   32'(bus.value),   32'h00);
    chk("midrst_valid",   32'(bus.valid),   32'h0);
    chk("midrst_seg_err", 32'(bus.seg_err), 32'h0);
    chk("midrst_stale",   32'(bus.stale),   32'h0);
    rst = 1'b0;
    drive(1'b1, SEG_4, 50, 0, SEG_4);
    chk("midrst_low_dropped", 32'(v_cnt), 32'd0);
    chk("midrst_no_err",      32'(e_cnt), 32'd0);
    drive(1'b0, SEG_5, 50, 0, SEG_5);
    drive(1'b1, SEG_3, 50, 0, SEG_3);
    chk("post_rst_valid_cnt", 32'(v_cnt), 32'd1);
    chk("post_rst_latency",   32'(v_lat), 32'(L + S + 2));
    chk("post_rst_value",     32'(bus.value), 32'h35);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
